// File: rtl/note_judge_pkg.sv
// note_pkg: shared judgement encodings, lane indices and note geometry for note_judge.
// Latency: none (types and constants only).
// Backpressure: none.
package note_pkg;

    typedef enum logic [1:0] {
        JUDGE_NONE    = 2'd0,
        JUDGE_MISS    = 2'd1,
        JUDGE_GOOD    = 2'd2,
        JUDGE_PERFECT = 2'd3
    } judge_e;

    localparam int LANE_R        = 0;
    localparam int LANE_B        = 1;
    localparam int OFFSET_CENTER = 8;
    localparam int NOTE_W        = 10;

    // Distance of the scroll phase from the hit-slot centre, |off - 8|.
    function automatic logic [3:0] center_dist(input logic [3:0] off);
        logic [3:0] c;
        c = 4'(OFFSET_CENTER);
        return (off >= c) ? (off - c) : (c - off);
    endfunction

endpackage

// File: rtl/note_judge_if.sv
// note_judge_if: note stream, raw buttons and scoring outputs of the judge stage.
// Latency: none (wires only).
// Backpressure: none; all signals are sampled every clk_div cycle.
// Ports: bottom/note_R/note_B/offset/finish flow master->slave,
//        score/combo/max_combo/judge/judge_lane/judge_valid flow slave->master.
interface note_judge_if;
    import note_pkg::*;

    logic [1:0]        bottom;
    logic [NOTE_W-1:0] note_R;
    logic [NOTE_W-1:0] note_B;
    logic [3:0]        offset;
    logic              finish;

    logic [15:0]       score;
    logic [7:0]        combo;
    logic [7:0]        max_combo;
    logic [1:0]        judge;
    logic              judge_lane;
    logic              judge_valid;

    modport master (
        output bottom, note_R, note_B, offset, finish,
        input  score, combo, max_combo, judge, judge_lane, judge_valid
    );

    modport slave (
        input  bottom, note_R, note_B, offset, finish,
        output score, combo, max_combo, judge, judge_lane, judge_valid
    );

endinterface

// File: rtl/note_judge_btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stability counter and rising-edge press pulse for one button.
// Latency: 2 + DEB_CYCLES cycles from a clean raw edge to the press pulse.
// Backpressure: none; the press pulse is one cycle wide and never held.
// Ports: clk, rst (async active-low), btn_raw in; level (debounced), press (pulse) out.
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;
    logic          press_q, press_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        cnt_d   = '0;
        deb_d   = deb_q;
        press_d = 1'b0;
        // Any sample agreeing with the debounced level restarts the count.
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                deb_d   = ~deb_q;
                press_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            press_q <= press_d;
        end
    end

    assign level = deb_q;
    assign press = press_q;

endmodule

// File: rtl/note_judge.sv
// note_judge: debounces both lane buttons and judges presses/misses against the hit slot into score and combo.
// Latency: outputs registered, one cycle after the press or step-boundary cycle.
// Backpressure: none; finish=1 freezes judging while the debouncers keep running.
// Ports: clk, rst (async active-low), bus (note_judge_if.slave).
// Option: EMPTY_PRESS_PENALTY_EN makes an empty press break the combo and report MISS.
module note_judge
    import note_pkg::*;
#(
    parameter int DEB_CYCLES  = 16,
    parameter int PERFECT_WIN = 2,
    parameter int PTS_PERFECT = 2,
    parameter int PTS_GOOD    = 1
) (
    input  logic        clk,
    input  logic        rst,
    note_judge_if.slave bus
);
    logic [1:0] deb_level, deb_press, lane_press;

    for (genvar i = 0; i < 2; i++) begin : g_lane
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (bus.bottom[i]),
            .level   (deb_level[i]),
            .press   (deb_press[i])
        );
    end

    // The press pulse and the debounced level rise together; requiring both
    // means a press is only credited while the lane is actually held.
    assign lane_press = deb_press & deb_level;

    logic [3:0]  offset_q, offset_d;
    logic [1:0]  slot_q, slot_d;
    logic [1:0]  consumed_q, consumed_d;
    logic [15:0] score_q, score_d;
    logic [7:0]  combo_q, combo_d;
    logic [7:0]  max_combo_q, max_combo_d;
    judge_e      judge_q, judge_d;
    logic        judge_lane_q, judge_lane_d;
    logic        judge_valid_q, judge_valid_d;

    logic        boundary, perfect, sel_lane;
    logic [1:0]  slot_now, cons_eff, miss, hit, penalty, lane_evt, n_hits;
    logic [16:0] pts, score_sum;
    logic [7:0]  combo_base;
    logic [8:0]  combo_sum;

    always_comb begin
        slot_now = {bus.note_B[0], bus.note_R[0]};
        boundary = (offset_q == 4'd15) && (bus.offset == 4'd0);
        perfect  = int'(center_dist(bus.offset)) <= PERFECT_WIN;

        // On a boundary the miss check sees the old slot; the press is judged
        // against the new slot with its consumed flag already cleared.
        cons_eff = boundary ? 2'b00 : consumed_q;
        miss     = boundary ? (slot_q & ~consumed_q) : 2'b00;
        hit      = lane_press & slot_now & ~cons_eff;
`ifdef EMPTY_PRESS_PENALTY_EN
        penalty  = lane_press & ~hit;
`else
        penalty  = 2'b00;
`endif
        lane_evt = miss | hit | penalty;
        n_hits   = {1'b0, hit[0]} + {1'b0, hit[1]};

        pts = 17'd0;
        for (int i = 0; i < 2; i++) begin
            if (hit[i]) pts = pts + (perfect ? 17'(PTS_PERFECT) : 17'(PTS_GOOD));
        end
        score_sum  = {1'b0, score_q} + pts;
        // Break the combo first, then count this cycle's hits on top.
        combo_base = (|(miss | penalty)) ? 8'd0 : combo_q;
        combo_sum  = {1'b0, combo_base} + {7'd0, n_hits};
        sel_lane   = ~lane_evt[LANE_R];

        offset_d      = bus.offset;
        slot_d        = slot_now;
        consumed_d    = consumed_q;
        score_d       = score_q;
        combo_d       = combo_q;
        max_combo_d   = max_combo_q;
        judge_d       = judge_q;
        judge_lane_d  = judge_lane_q;
        judge_valid_d = 1'b0;

        if (!bus.finish) begin
            consumed_d = cons_eff | hit;
            if (|lane_evt) begin
                score_d       = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                combo_d       = combo_sum[8] ? 8'hFF : combo_sum[7:0];
                max_combo_d   = (combo_d > max_combo_q) ? combo_d : max_combo_q;
                judge_valid_d = 1'b1;
                judge_lane_d  = sel_lane;
                if (miss[sel_lane] || penalty[sel_lane]) judge_d = JUDGE_MISS;
                else if (perfect)                        judge_d = JUDGE_PERFECT;
                else                                     judge_d = JUDGE_GOOD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            offset_q      <= 4'd0;
            slot_q        <= 2'b00;
            consumed_q    <= 2'b00;
            score_q       <= 16'd0;
            combo_q       <= 8'd0;
            max_combo_q   <= 8'd0;
            judge_q       <= JUDGE_NONE;
            judge_lane_q  <= 1'b0;
            judge_valid_q <= 1'b0;
        end else begin
            offset_q      <= offset_d;
            slot_q        <= slot_d;
            consumed_q    <= consumed_d;
            score_q       <= score_d;
            combo_q       <= combo_d;
            max_combo_q   <= max_combo_d;
            judge_q       <= judge_d;
            judge_lane_q  <= judge_lane_d;
            judge_valid_q <= judge_valid_d;
        end
    end

    assign bus.score       = score_q;
    assign bus.combo       = combo_q;
    assign bus.max_combo   = max_combo_q;
    assign bus.judge       = judge_q;
    assign bus.judge_lane  = judge_lane_q;
    assign bus.judge_valid = judge_valid_q;

endmodule

// File: tb/tb_note_judge.sv
// tb_note_judge: directed scenarios plus randomized presses on a random note chart for note_judge.
// Latency: a press raised in cycle n is judged in cycle n+18; outputs are checked on the falling edge after.
// Backpressure: none.
module tb_note_judge;
    import note_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    note_judge_if bus();
    note_judge dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;

    // Scroll time: step = t/16, offset = t%16. The chart holds each step's bit0.
    int t = 0;
    int cyc = 0;
    bit chart_r [0:1023];
    bit chart_b [0:1023];
    logic [1:0] btn = 2'b00;
    logic fin = 1'b0;
    int vld_cnt = 0;

    // Reference model state.
    int m_score, m_combo, m_max, m_judge, m_lane, m_valid, m_offq;
    bit m_slotq [2];
    bit m_cons [2];
    bit m_raw [2];
    bit m_deb [2];
    int m_chg [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] note_vec(input bit lane_b, input int stp);
        logic [9:0] v;
        for (int k = 0; k < 10; k++) v[k] = lane_b ? chart_b[stp + k] : chart_r[stp + k];
        return v;
    endfunction

    task automatic model_reset();
        m_score = 0; m_combo = 0; m_max = 0; m_judge = 0; m_lane = 0; m_valid = 0; m_offq = 0;
        for (int i = 0; i < 2; i++) begin
            m_slotq[i] = 0; m_cons[i] = 0; m_deb[i] = 0; m_raw[i] = btn[i]; m_chg[i] = cyc - 100;
        end
    endtask

    task automatic tick();
        logic [9:0] nr, nb;
        int off, stp, d, pts, nh, jl, jc;
        bit bnd, perf, rstc, slot_now, ce, ms, ht, pn;
        bit prs [2];
        off = t % 16;
        stp = t / 16;
        nr = note_vec(1'b0, stp);
        nb = note_vec(1'b1, stp);
        bus.bottom = btn; bus.offset = 4'(off); bus.note_R = nr; bus.note_B = nb; bus.finish = fin;

        if (!rst) begin
            model_reset();
        end else begin
            // A button level that has been steady for 18 cycles becomes the debounced level.
            for (int i = 0; i < 2; i++) begin
                if (btn[i] != m_raw[i]) begin m_raw[i] = btn[i]; m_chg[i] = cyc; end
                prs[i] = 0;
                if (cyc - m_chg[i] == 18 && m_raw[i] != m_deb[i]) begin
                    m_deb[i] = m_raw[i];
                    prs[i] = m_raw[i];
                end
            end
            bnd = (m_offq == 15 && off == 0);
            d = (off >= 8) ? off - 8 : 8 - off;
            perf = (d <= 2);
            m_valid = 0;
            if (!fin) begin
                pts = 0; nh = 0; rstc = 0; jl = -1; jc = 0;
                for (int i = 0; i < 2; i++) begin
                    slot_now = (i == 0) ? nr[0] : nb[0];
                    ce = bnd ? 1'b0 : m_cons[i];
                    ms = bnd && m_slotq[i] && !m_cons[i];
                    ht = prs[i] && slot_now && !ce;
                    pn = 0;
`ifdef EMPTY_PRESS_PENALTY_EN
                    pn = prs[i] && !ht;
`endif
                    if (ht) begin pts += perf ? 2 : 1; nh++; end
                    if (ms || pn) rstc = 1;
                    m_cons[i] = ce || ht;
                    if (jl < 0 && (ms || ht || pn)) begin
                        jl = i;
                        jc = (ms || pn) ? 1 : (perf ? 3 : 2);
                    end
                end
                if (jl >= 0) begin
                    m_combo = (rstc ? 0 : m_combo) + nh;
                    if (m_combo > 255) m_combo = 255;
                    m_score = m_score + pts;
                    if (m_score > 65535) m_score = 65535;
                    if (m_combo > m_max) m_max = m_combo;
                    m_judge = jc; m_lane = jl; m_valid = 1;
                end
            end
            m_offq = off;
            m_slotq[0] = nr[0];
            m_slotq[1] = nb[0];
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
        t++;
        if (bus.judge_valid === 1'b1) vld_cnt++;
        check("score", 32'(bus.score), 32'(m_score));
        check("combo", 32'(bus.combo), 32'(m_combo));
        check("max_combo", 32'(bus.max_combo), 32'(m_max));
        check("judge", 32'(bus.judge), 32'(m_judge));
        check("judge_lane", 32'(bus.judge_lane), 32'(m_lane));
        check("judge_valid", 32'(bus.judge_valid), 32'(m_valid));
    endtask

    // Raise the lanes in mask so the press lands on scroll time target, then release.
    task automatic press(input logic [1:0] mask, input int target);
        while (t < target - 18) tick();
        btn = mask;
        repeat (20) tick();
        btn = 2'b00;
        repeat (20) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_score"}, 32'(bus.score), 32'd0);
        check({tag, "_combo"}, 32'(bus.combo), 32'd0);
        check({tag, "_max"}, 32'(bus.max_combo), 32'd0);
        check({tag, "_judge"}, 32'(bus.judge), 32'd0);
        check({tag, "_lane"}, 32'(bus.judge_lane), 32'd0);
        check({tag, "_vld"}, 32'(bus.judge_valid), 32'd0);
    endtask

    initial begin
        bus.bottom = 2'b00; bus.note_R = '0; bus.note_B = '0; bus.offset = 4'd0; bus.finish = 1'b0;
        model_reset();
        #2 rst = 1'b0;
        #1 check_all_zero("reset");
        tick();
        tick();
        rst = 1'b1;

        // PERFECT at offset 9.
        chart_r[10] = 1;
        press(2'b01, 10 * 16 + 9);
        check("perfect_judge", 32'(bus.judge), 32'd3);
        check("perfect_score", 32'(bus.score), 32'd2);
        check("perfect_combo", 32'(bus.combo), 32'd1);

        // GOOD at offset 3.
        chart_r[14] = 1;
        press(2'b01, 14 * 16 + 3);
        check("good_judge", 32'(bus.judge), 32'd2);
        check("good_score", 32'(bus.score), 32'd3);
        check("good_combo", 32'(bus.combo), 32'd2);

        // Unpressed blue note misses at the following boundary.
        chart_b[17] = 1;
        while (t < 300) tick();
        check("miss_judge", 32'(bus.judge), 32'd1);
        check("miss_lane", 32'(bus.judge_lane), 32'd1);
        check("miss_combo", 32'(bus.combo), 32'd0);
        check("miss_score", 32'(bus.score), 32'd3);
        check("miss_max", 32'(bus.max_combo), 32'd2);

        // Both lanes hit at the centre in one cycle.
        chart_r[21] = 1; chart_b[21] = 1;
        press(2'b11, 21 * 16 + 8);
        check("dual_score", 32'(bus.score), 32'd7);
        check("dual_combo", 32'(bus.combo), 32'd2);
        check("dual_lane", 32'(bus.judge_lane), 32'd0);
        check("dual_judge", 32'(bus.judge), 32'd3);

        // Press on an empty slot.
        press(2'b01, 25 * 16 + 8);
        check("empty_score", 32'(bus.score), 32'd7);
`ifdef EMPTY_PRESS_PENALTY_EN
        check("empty_combo", 32'(bus.combo), 32'd0);
        check("empty_judge", 32'(bus.judge), 32'd1);
`else
        check("empty_combo", 32'(bus.combo), 32'd2);
        check("empty_judge", 32'(bus.judge), 32'd3);
`endif

        // Bounce, then hold: one press 18 cycles after the last edge.
        chart_r[29] = 1;
        while (t < 443) tick();
        vld_cnt = 0;
        for (int k = 0; k < 9; k++) begin
            btn = (k % 2 == 0) ? 2'b01 : 2'b00;
            tick();
        end
        while (t < 469) tick();
        check("bounce_quiet", 32'(vld_cnt), 32'd0);
        tick();
        check("bounce_press", 32'(bus.judge_valid), 32'd1);
        while (t < 472) tick();
        btn = 2'b00;
        repeat (20) tick();
        check("bounce_once", 32'(vld_cnt), 32'd1);

        // finish freezes judging.
        while (t < 500) tick();
        fin = 1'b1;
        vld_cnt = 0;
        chart_r[33] = 1;
        press(2'b01, 33 * 16 + 8);
        check("finish_vld", 32'(vld_cnt), 32'd0);
        check("finish_score", 32'(bus.score), 32'd8);
        fin = 1'b0;

        // Score saturation from 0xFFFE.
        while (t < 570) tick();
        force dut.score_q = 16'hFFFE;
        m_score = 16'hFFFE;
        tick();
        release dut.score_q;
        chart_r[38] = 1;
        press(2'b01, 38 * 16 + 8);
        check("sat_score", 32'(bus.score), 32'hFFFF);

        // Asynchronous reset mid-song.
        rst = 1'b0;
        #1 check_all_zero("midreset");
        tick();
        tick();
        rst = 1'b1;

        // Random chart and presses, with finish toggling now and then.
        for (int s = t / 16 + 1; s < 1024; s++) begin
            chart_r[s] = 1'($urandom_range(0, 1));
            chart_b[s] = 1'($urandom_range(0, 1));
        end
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 7) == 0) fin = ~fin;
            press(2'($urandom_range(1, 3)), t + 18 + $urandom_range(0, 15));
        end
        fin = 1'b0;
        repeat (40) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
